// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: decode-stage
// forward selects, load-use and mult/div stalls, and a saturating stall counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        UseRsD,
  input  logic        UseRtD,
  input  logic        MdUseD,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        MdStartE,
  input  logic        DivE,
  output logic        ForwardADN1,
  output logic        ForwardBDN1,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        ForwardADN2,
  output logic        ForwardBDN2,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        MdBusy,
  output logic [31:0] StallCount
);

  logic       match_a_e, match_a_m, match_a_w;
  logic       match_b_e, match_b_m, match_b_w;
  logic       ld_stall, md_stall, stall;
  logic [7:0] cnt;
  logic [31:0] stall_cnt;

  // Register 0 is hardwired to zero, so a write to it never produces a match.
  always_comb begin
    match_a_e = RegWriteE & (WriteRegE != 5'd0) & (WriteRegE == RsD) & UseRsD;
    match_a_m = RegWriteM & (WriteRegM != 5'd0) & (WriteRegM == RsD) & UseRsD;
    match_a_w = RegWriteW & (WriteRegW != 5'd0) & (WriteRegW == RsD) & UseRsD;
    match_b_e = RegWriteE & (WriteRegE != 5'd0) & (WriteRegE == RtD) & UseRtD;
    match_b_m = RegWriteM & (WriteRegM != 5'd0) & (WriteRegM == RtD) & UseRtD;
    match_b_w = RegWriteW & (WriteRegW != 5'd0) & (WriteRegW == RtD) & UseRtD;
  end

  always_comb begin
    ForwardADN1 = match_a_e & ~MemtoRegE;
    ForwardAD   = ~match_a_e & match_a_m & ~MemtoRegM;
    ForwardADN2 = ~match_a_e & ~match_a_m & match_a_w;
    ForwardBDN1 = match_b_e & ~MemtoRegE;
    ForwardBD   = ~match_b_e & match_b_m & ~MemtoRegM;
    ForwardBDN2 = ~match_b_e & ~match_b_m & match_b_w;
  end

  always_comb begin
    ld_stall = ((match_a_e | match_b_e) & MemtoRegE) |
               ((match_a_m | match_b_m) & MemtoRegM);
    md_stall = MdUseD & (MdBusy | MdStartE);
    stall    = ld_stall | md_stall;
    StallF   = stall;
    StallD   = stall;
    FlushE   = stall;
  end

  // A start arriving while the unit is already busy is dropped, not queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (MdStartE && (cnt == 8'd0)) begin
      cnt <= DivE ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign MdBusy = (cnt != 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign StallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding priority, load-use
// and mult/div stalls, busy window timing, reset behaviour and counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RsD, RtD, WriteRegE, WriteRegM, WriteRegW;
  logic        UseRsD, UseRtD, MdUseD;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic        MdStartE, DivE;
  logic        ForwardADN1, ForwardBDN1, ForwardAD, ForwardBD, ForwardADN2, ForwardBDN2;
  logic        StallF, StallD, FlushE, MdBusy;
  logic [31:0] StallCount;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] exp_sc = '0;

  hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
    .MdUseD(MdUseD), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MdStartE(MdStartE), .DivE(DivE),
    .ForwardADN1(ForwardADN1), .ForwardBDN1(ForwardBDN1), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .ForwardADN2(ForwardADN2), .ForwardBDN2(ForwardBDN2),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MdBusy(MdBusy),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // {ADN1, AD, ADN2, BDN1, BD, BDN2, StallF, StallD, FlushE}
  function automatic logic [8:0] comb_vec();
    return {ForwardADN1, ForwardAD, ForwardADN2, ForwardBDN1, ForwardBD, ForwardBDN2,
            StallF, StallD, FlushE};
  endfunction

  task automatic idle();
    RsD = '0; RtD = '0; UseRsD = 1'b0; UseRtD = 1'b0; MdUseD = 1'b0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; MdStartE = 1'b0; DivE = 1'b0;
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (MdBusy !== 1'b0) begin failures++; $display("FAIL reset_mdbusy got=%b exp=0", MdBusy); end
    checks++;
    if (StallCount !== 32'd0) begin failures++; $display("FAIL reset_stallcount got=%0h exp=0", StallCount); end
    checks++;
    if (comb_vec() !== 9'b0) begin failures++; $display("FAIL reset_comb got=%b exp=%b", comb_vec(), 9'b0); end
    reset = 1'b0;
    exp_sc = '0;
  endtask

  task automatic test_alu_forward_e();
    align();
    RegWriteE = 1'b1; WriteRegE = 5'd5; RsD = 5'd5; UseRsD = 1'b1;
    #1;
    checks++;
    if (comb_vec() !== 9'b100_000_000) begin failures++; $display("FAIL alu_fwd_e got=%b exp=%b", comb_vec(), 9'b100_000_000); end
    UseRsD = 1'b0;
    #1;
    checks++;
    if (comb_vec() !== 9'b0) begin failures++; $display("FAIL alu_fwd_e_unused got=%b exp=%b", comb_vec(), 9'b0); end
    idle();
  endtask

  task automatic test_priority();
    logic [8:0] exp_v [3];
    exp_v[0] = 9'b000_100_000;
    exp_v[1] = 9'b000_010_000;
    exp_v[2] = 9'b000_001_000;
    align();
    WriteRegE = 5'd7; WriteRegM = 5'd7; WriteRegW = 5'd7;
    RegWriteE = 1'b1; RegWriteM = 1'b1; RegWriteW = 1'b1;
    RtD = 5'd7; UseRtD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) RegWriteE = 1'b0;
      if (i == 2) RegWriteM = 1'b0;
      #1;
      checks++;
      if (comb_vec() !== exp_v[i]) begin failures++; $display("FAIL priority_%0d got=%b exp=%b", i, comb_vec(), exp_v[i]); end
      checks++;
      if ($countones({ForwardBDN1, ForwardBD, ForwardBDN2}) > 1) begin
        failures++; $display("FAIL onehot_b_%0d got=%b exp=at_most_one", i, {ForwardBDN1, ForwardBD, ForwardBDN2});
      end
    end
    // Same producers on operand A too, with all three stages matching.
    RegWriteE = 1'b1; RegWriteM = 1'b1; RsD = 5'd7; UseRsD = 1'b1;
    #1;
    checks++;
    if ($countones({ForwardADN1, ForwardAD, ForwardADN2}) != 1 || ForwardADN1 !== 1'b1) begin
      failures++; $display("FAIL onehot_a got=%b exp=100", {ForwardADN1, ForwardAD, ForwardADN2});
    end
    idle();
  endtask

  task automatic test_reg_zero();
    align();
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    RegWriteE = 1'b1; RegWriteM = 1'b1; RegWriteW = 1'b1; MemtoRegE = 1'b1;
    RsD = 5'd0; RtD = 5'd0; UseRsD = 1'b1; UseRtD = 1'b1;
    #1;
    checks++;
    if (comb_vec() !== 9'b0) begin failures++; $display("FAIL reg_zero got=%b exp=%b", comb_vec(), 9'b0); end
    idle();
  endtask

  task automatic test_load_use();
    align();
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
    #1;
    checks++;
    if (comb_vec() !== 9'b000_000_111) begin failures++; $display("FAIL load_use_e got=%b exp=%b", comb_vec(), 9'b000_000_111); end
    repeat (3) @(posedge clk);
    #1;
    exp_sc += 32'd3;
    checks++;
    if (StallCount !== exp_sc) begin failures++; $display("FAIL load_use_count got=%0d exp=%0d", StallCount, exp_sc); end
    WriteRegE = 5'd0; RsD = 5'd0;
    #1;
    checks++;
    if (comb_vec() !== 9'b0) begin failures++; $display("FAIL load_use_r0 got=%b exp=%b", comb_vec(), 9'b0); end
    align();
    checks++;
    if (StallCount !== exp_sc) begin failures++; $display("FAIL load_use_r0_count got=%0d exp=%0d", StallCount, exp_sc); end
    idle();
  endtask

  task automatic test_load_m();
    align();
    RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd8; RtD = 5'd8; UseRtD = 1'b1;
    #1;
    checks++;
    if (comb_vec() !== 9'b000_000_111) begin failures++; $display("FAIL load_m got=%b exp=%b", comb_vec(), 9'b000_000_111); end
    idle();
  endtask

  task automatic test_div_window();
    int unsigned busy = 0;
    int unsigned mism = 0;
    int fall = -1;
    align();
    MdStartE = 1'b1; DivE = 1'b1; MdUseD = 1'b1;
    #1;
    checks++;
    if (comb_vec() !== 9'b000_000_111 || MdBusy !== 1'b0) begin
      failures++; $display("FAIL div_start got=%b/%b exp=%b/0", comb_vec(), MdBusy, 9'b000_000_111);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 0 || i == 10) MdStartE = 1'b0;
      #1;
      if (MdBusy) busy++;
      else if (fall < 0) fall = i;
      if (StallF !== MdBusy) mism++;
      if (busy == 10 && i == 9) begin MdStartE = 1'b1; DivE = 1'b1; end
    end
    exp_sc += 32'd33;
    checks++;
    if (busy != 32) begin failures++; $display("FAIL div_busy_len got=%0d exp=32", busy); end
    checks++;
    if (fall != 32) begin failures++; $display("FAIL div_busy_fall got=%0d exp=32", fall); end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL div_stall_track got=%0d exp=0", mism); end
    checks++;
    if (StallCount !== exp_sc) begin failures++; $display("FAIL div_stall_count got=%0d exp=%0d", StallCount, exp_sc); end
    idle();
  endtask

  task automatic test_mult_window();
    int unsigned busy = 0;
    align();
    MdStartE = 1'b1; DivE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      MdStartE = 1'b0;
      #1;
      if (MdBusy) busy++;
    end
    checks++;
    if (busy != 4) begin failures++; $display("FAIL mult_busy_len got=%0d exp=4", busy); end
    checks++;
    if (StallCount !== exp_sc) begin failures++; $display("FAIL mult_no_stall got=%0d exp=%0d", StallCount, exp_sc); end
    idle();
  endtask

  task automatic test_reset_mid_mult();
    align();
    MdStartE = 1'b1; DivE = 1'b0;
    align();
    MdStartE = 1'b0;
    checks++;
    if (MdBusy !== 1'b1) begin failures++; $display("FAIL mult_started got=%b exp=1", MdBusy); end
    align();
    reset = 1'b1;
    align();
    reset = 1'b0;
    exp_sc = '0;
    checks++;
    if (MdBusy !== 1'b0) begin failures++; $display("FAIL reset_mid_mult_busy got=%b exp=0", MdBusy); end
    checks++;
    if (StallCount !== exp_sc) begin failures++; $display("FAIL reset_mid_mult_count got=%0d exp=0", StallCount); end
    // Reset wins over a same-cycle start and over a same-cycle stall.
    reset = 1'b1; MdStartE = 1'b1; DivE = 1'b1; MdUseD = 1'b1;
    align();
    reset = 1'b0;
    idle();
    checks++;
    if (MdBusy !== 1'b0 || StallCount !== 32'd0) begin
      failures++; $display("FAIL reset_priority got=%b/%0d exp=0/0", MdBusy, StallCount);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9; UseRtD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (StallCount !== 32'hFFFF_FFFF) begin
        failures++; $display("FAIL saturate_%0d got=%0h exp=ffffffff", i, StallCount);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_alu_forward_e();
    test_priority();
    test_reg_zero();
    test_load_use();
    test_load_m();
    test_div_window();
    test_mult_window();
    test_reset_mid_mult();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Generates the decode-stage forward selects (ForwardAD/BD, ForwardADN1/BDN1, ForwardADN2/BDN2) consumed by the decode operand mux.
- Generates pipeline stall/flush controls and tracks the multicycle mult/div unit's busy window with an internal counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 4, cycles HI/LO stays busy after a mult start (1..255)
- DIV_CYCLES, 32, cycles HI/LO stays busy after a div start (1..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- RsD, RtD  in  5 each  decode source register numbers
- UseRsD, UseRtD  in  1 each  decode instruction actually reads Rs / Rt
- MdUseD  in  1  decode instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes the register file
- MemtoRegE, MemtoRegM  in  1 each  stage instruction is a load
- MdStartE  in  1  execute instruction starts mult/div this cycle
- DivE  in  1  with MdStartE: 1 = div, 0 = mult
- ForwardADN1, ForwardBDN1  out  1 each  select ALUOutE for RD1D / RD2D
- ForwardAD, ForwardBD  out  1 each  select ALUOutM
- ForwardADN2, ForwardBDN2  out  1 each  select ResultW (register file is read-first)
- StallF, StallD  out  1 each  hold PC and IF/ID register
- FlushE  out  1  insert bubble into ID/EX
- MdBusy  out  1  mult/div result not yet available
- StallCount  out  32  saturating count of stalled cycles

Behaviour:
- Forward selects are combinational. For operand A (B is identical using RtD/UseRtD):
  - match_X = RegWriteX & (WriteRegX != 0) & (WriteRegX == RsD) & UseRsD, for X = E, M, W.
  - Priority is youngest first: E > M > W.
  - ForwardADN1 = match_E & ~MemtoRegE.
  - ForwardAD = ~match_E & match_M & ~MemtoRegM.
  - ForwardADN2 = ~match_E & ~match_M & match_W.
  - At most one of the three selects is high per operand at any time. The bench must check this.
- Register 0 never matches, never forwards and never causes a stall.
- Stall sources (combinational):
  - ld_stall = (match_E & MemtoRegE) | (match_M & MemtoRegM), evaluated on either operand.
  - md_stall = MdUseD & (MdBusy | MdStartE).
  - stall = ld_stall | md_stall.
  - StallF = StallD = FlushE = stall.
- Forward selects may still be asserted during a stall; they are don't-care because the decode result is discarded.
- Mult/div counter (8-bit cnt, registered):
  - reset: cnt = 0.
  - MdStartE & (cnt == 0): cnt <= DivE ? DIV_CYCLES : MULT_CYCLES.
  - else if cnt != 0: cnt <= cnt - 1.
  - MdStartE while cnt != 0 is ignored: no reload, decrement continues.
  - MdBusy = (cnt != 0). It is high for exactly N cycles following the start edge.
- StallCount:
  - reset: 0.
  - Increments on each cycle where stall = 1.
  - Saturates at 32'hFFFFFFFF with no wrap.
- Reset values:
  - cnt = 0, so MdBusy = 0.
  - StallCount = 0.
  - All combinational outputs follow their inputs.
  - Reset asserted mid-divide aborts the busy window on the next edge. MdBusy = 0 in the cycle after reset.
- Reset has priority over MdStartE in the same cycle.

Test Plan:
- ALU producer in E: RegWriteE=1, MemtoRegE=0, WriteRegE=5, RsD=5, UseRsD=1 -> ForwardADN1=1, ForwardAD=0, ForwardADN2=0, stall=0.
- Same register in E, M and W: WriteRegE=WriteRegM=WriteRegW=7 (all writing, no loads), RtD=7 -> only ForwardBDN1=1. Drop RegWriteE -> only ForwardBD=1. Drop RegWriteM -> only ForwardBDN2=1.
- Load-use hazards:
  - MemtoRegE=1, WriteRegE=8, RsD=8 -> StallF=StallD=FlushE=1, StallCount +1 per stalled cycle.
  - Repeat with WriteRegE=0 -> no stall, no forward.
  - Load in M (MemtoRegM=1, WriteRegM=8) -> stall=1, ForwardAD=0.
- Divide busy window: MdStartE=1, DivE=1 for one cycle -> MdBusy high for exactly 32 cycles. MdUseD=1 during the start cycle and the busy window -> stall each cycle; stall drops in the cycle MdBusy falls. A second MdStartE at busy cycle 10 must not extend the window.
- Reset mid-mult: assert reset 2 cycles after a mult start -> MdBusy=0 and StallCount=0 on the following cycle.
- Saturation: force 2^32+3 stalled cycles (or preload the counter via hierarchical force to 32'hFFFFFFFE) -> StallCount holds at 32'hFFFFFFFF.
